id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. Captures decoded operands, register specifiers and control bits from ID each cycle and presents them to EX, where `IDEX_Rs`, `IDEX_Rt` and `IDEX_RegWrite` drive the forwarding unit and the EX operand muxes. Inserts a one-cycle bubble and freezes PC and IF/ID on a load-use dependency. Squashes on branch flush.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 19 +
 rtl/id_ex_stage.sv | 157 +++++++++++++++
 tb/tb_id_ex_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and control-bundle layout for the pipeline registers
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam int ALUOP_W = 3;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Control bundle is {RegWrite, MemRead, MemWrite, MemtoReg, RegDst, ALUSrc, ALUOp}.
  // ALUOp occupies the low bits; the single-bit flags sit above it at these offsets.
  localparam int CTRL_FLAGS = 6;
  localparam int CTRL_W = CTRL_FLAGS + ALUOP_W;
  localparam int CB_ALUSRC = 0;
  localparam int CB_REGDST = 1;
  localparam int CB_MEMTOREG = 2;
  localparam int CB_MEMWRITE = 3;
  localparam int CB_MEMREAD = 4;
  localparam int CB_REGWRITE = 5;

  // Bundle width for a stage built with a non-default ALUOp width.
  function automatic int ctrl_w(input int aluop_w);
    return CTRL_FLAGS + aluop_w;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between EX and ID
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  output logic             LoadUseStall
);

  // A load in EX stalls a consumer in ID that reads its destination; $zero never stalls.
  always_comb begin
    LoadUseStall = IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
                   ((IDEX_Rt == ID_Rs) || (ID_UsesRt && (IDEX_Rt == ID_Rt)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion; optional IDEX_STATS_EN stall counter
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [pipeline_pkg::REG_W-1:0] ID_Rs,
  input  logic [pipeline_pkg::REG_W-1:0] ID_Rt,
  input  logic [pipeline_pkg::REG_W-1:0] ID_Rd,
  input  logic                           ID_UsesRt,
  input  logic [DATA_W-1:0]              ID_ReadData1,
  input  logic [DATA_W-1:0]              ID_ReadData2,
  input  logic [DATA_W-1:0]              ID_SignExt,
  input  logic                           ID_RegWrite,
  input  logic                           ID_MemRead,
  input  logic                           ID_MemWrite,
  input  logic                           ID_MemtoReg,
  input  logic                           ID_RegDst,
  input  logic                           ID_ALUSrc,
  input  logic [ALUOP_W-1:0]             ID_ALUOp,
  input  logic                           Flush,
  input  logic                           Hold,
  output logic [pipeline_pkg::REG_W-1:0] IDEX_Rs,
  output logic [pipeline_pkg::REG_W-1:0] IDEX_Rt,
  output logic [pipeline_pkg::REG_W-1:0] IDEX_Rd,
  output logic [DATA_W-1:0]              IDEX_ReadData1,
  output logic [DATA_W-1:0]              IDEX_ReadData2,
  output logic [DATA_W-1:0]              IDEX_SignExt,
  output logic                           IDEX_RegWrite,
  output logic                           IDEX_MemRead,
  output logic                           IDEX_MemWrite,
  output logic                           IDEX_MemtoReg,
  output logic                           IDEX_RegDst,
  output logic                           IDEX_ALUSrc,
  output logic [ALUOP_W-1:0]             IDEX_ALUOp,
  output logic                           PCWrite,
  output logic                           IFID_Write,
`ifdef IDEX_STATS_EN
  output logic [31:0]                    StallCount,
`endif
  output logic                           LoadUseStall
);

  localparam int RW = pipeline_pkg::REG_W;
  localparam int CW = pipeline_pkg::ctrl_w(ALUOP_W);

  logic [RW-1:0]     rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [DATA_W-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic [CW-1:0]     ctrl_in, ctrl_d, ctrl_q;
  logic              advance;

  assign ctrl_in = {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg,
                    ID_RegDst, ID_ALUSrc, ID_ALUOp};

  load_use_detect u_load_use_detect (
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_Rt      (IDEX_Rt),
    .ID_Rs        (ID_Rs),
    .ID_Rt        (ID_Rt),
    .ID_UsesRt    (ID_UsesRt),
    .LoadUseStall (LoadUseStall)
  );

  // Front end advances unless frozen by Hold or by a hazard that Flush is not overriding.
  always_comb begin
    advance    = !Hold && (Flush || !LoadUseStall);
    PCWrite    = advance;
    IFID_Write = advance;
  end

  // Next-state priority: Hold keeps, Flush or hazard loads a bubble, otherwise capture ID.
  always_comb begin
    rs_d   = rs_q;
    rt_d   = rt_q;
    rd_d   = rd_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    ctrl_d = ctrl_q;
    if (!Hold) begin
      if (Flush || LoadUseStall) begin
        rs_d   = '0;
        rt_d   = '0;
        rd_d   = '0;
        rd1_d  = '0;
        rd2_d  = '0;
        imm_d  = '0;
        ctrl_d = '0;
      end else begin
        rs_d   = ID_Rs;
        rt_d   = ID_Rt;
        rd_d   = ID_Rd;
        rd1_d  = ID_ReadData1;
        rd2_d  = ID_ReadData2;
        imm_d  = ID_SignExt;
        ctrl_d = ctrl_in;
      end
    end
  end

  // Register bank; reset forces the bubble state so no stale stall survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      ctrl_q <= '0;
    end else begin
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign IDEX_Rs        = rs_q;
  assign IDEX_Rt        = rt_q;
  assign IDEX_Rd        = rd_q;
  assign IDEX_ReadData1 = rd1_q;
  assign IDEX_ReadData2 = rd2_q;
  assign IDEX_SignExt   = imm_q;
  assign IDEX_RegWrite  = ctrl_q[ALUOP_W + pipeline_pkg::CB_REGWRITE];
  assign IDEX_MemRead   = ctrl_q[ALUOP_W + pipeline_pkg::CB_MEMREAD];
  assign IDEX_MemWrite  = ctrl_q[ALUOP_W + pipeline_pkg::CB_MEMWRITE];
  assign IDEX_MemtoReg  = ctrl_q[ALUOP_W + pipeline_pkg::CB_MEMTOREG];
  assign IDEX_RegDst    = ctrl_q[ALUOP_W + pipeline_pkg::CB_REGDST];
  assign IDEX_ALUSrc    = ctrl_q[ALUOP_W + pipeline_pkg::CB_ALUSRC];
  assign IDEX_ALUOp     = ctrl_q[ALUOP_W-1:0];

`ifdef IDEX_STATS_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Count only bubbles actually inserted for a hazard; wraps naturally at 32 bits.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, (LoadUseStall && !Flush && !Hold)};
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against a behavioural pipeline model
module tb_id_ex_stage;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regdst;
    logic        alusrc;
    logic [2:0]  aluop;
  } ex_t;

  typedef struct packed {
    ex_t         f;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic        ID_UsesRt;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_SignExt;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegDst, ID_ALUSrc;
  logic [2:0]  ID_ALUOp;
  logic        Flush, Hold;
  logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_Rd;
  logic [31:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_SignExt;
  logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_RegDst, IDEX_ALUSrc;
  logic [2:0]  IDEX_ALUOp;
  logic        PCWrite, IFID_Write, LoadUseStall;
`ifdef IDEX_STATS_EN
  logic [31:0] StallCount;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  ex_t  ex_m;
  logic [31:0] stall_m;

  id_ex_stage #(.DATA_W(32), .ALUOP_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_Rd          (ID_Rd),
    .ID_UsesRt      (ID_UsesRt),
    .ID_ReadData1   (ID_ReadData1),
    .ID_ReadData2   (ID_ReadData2),
    .ID_SignExt     (ID_SignExt),
    .ID_RegWrite    (ID_RegWrite),
    .ID_MemRead     (ID_MemRead),
    .ID_MemWrite    (ID_MemWrite),
    .ID_MemtoReg    (ID_MemtoReg),
    .ID_RegDst      (ID_RegDst),
    .ID_ALUSrc      (ID_ALUSrc),
    .ID_ALUOp       (ID_ALUOp),
    .Flush          (Flush),
    .Hold           (Hold),
    .IDEX_Rs        (IDEX_Rs),
    .IDEX_Rt        (IDEX_Rt),
    .IDEX_Rd        (IDEX_Rd),
    .IDEX_ReadData1 (IDEX_ReadData1),
    .IDEX_ReadData2 (IDEX_ReadData2),
    .IDEX_SignExt   (IDEX_SignExt),
    .IDEX_RegWrite  (IDEX_RegWrite),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_MemWrite  (IDEX_MemWrite),
    .IDEX_MemtoReg  (IDEX_MemtoReg),
    .IDEX_RegDst    (IDEX_RegDst),
    .IDEX_ALUSrc    (IDEX_ALUSrc),
    .IDEX_ALUOp     (IDEX_ALUOp),
    .PCWrite        (PCWrite),
    .IFID_Write     (IFID_Write),
`ifdef IDEX_STATS_EN
    .StallCount     (StallCount),
`endif
    .LoadUseStall   (LoadUseStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t mk(input int rs, input int rt, input int rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                             input logic rw, input logic mr, input logic mw, input logic m2r,
                             input logic rdst, input logic asrc, input logic [2:0] op);
    ex_t e;
    e.rs = 5'(rs); e.rt = 5'(rt); e.rd = 5'(rd);
    e.rd1 = d1; e.rd2 = d2; e.imm = im;
    e.regwrite = rw; e.memread = mr; e.memwrite = mw; e.memtoreg = m2r;
    e.regdst = rdst; e.alusrc = asrc; e.aluop = op;
    return e;
  endfunction

  function automatic ex_t dut_ex();
    ex_t e;
    e.rs = IDEX_Rs; e.rt = IDEX_Rt; e.rd = IDEX_Rd;
    e.rd1 = IDEX_ReadData1; e.rd2 = IDEX_ReadData2; e.imm = IDEX_SignExt;
    e.regwrite = IDEX_RegWrite; e.memread = IDEX_MemRead; e.memwrite = IDEX_MemWrite;
    e.memtoreg = IDEX_MemtoReg; e.regdst = IDEX_RegDst; e.alusrc = IDEX_ALUSrc;
    e.aluop = IDEX_ALUOp;
    return e;
  endfunction

  // Reference rule: a load in EX whose nonzero destination is read by the ID instruction.
  function automatic logic model_hazard(input ex_t ex, input ex_t id, input logic uses_rt);
    return ex.memread && (ex.rt != 0) && ((ex.rt == id.rs) || (uses_rt && (ex.rt == id.rt)));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input ex_t id, input logic ur, input logic fl, input logic hd);
    ID_Rs = id.rs; ID_Rt = id.rt; ID_Rd = id.rd; ID_UsesRt = ur;
    ID_ReadData1 = id.rd1; ID_ReadData2 = id.rd2; ID_SignExt = id.imm;
    ID_RegWrite = id.regwrite; ID_MemRead = id.memread; ID_MemWrite = id.memwrite;
    ID_MemtoReg = id.memtoreg; ID_RegDst = id.regdst; ID_ALUSrc = id.alusrc;
    ID_ALUOp = id.aluop; Flush = fl; Hold = hd;
  endtask

  // Called at a falling edge: drive, check same-cycle outputs, predict the next EX contents.
  task automatic cycle(input ex_t id, input logic ur, input logic fl, input logic hd);
    logic hz, adv;
    ex_t  nxt;
    exp_t e;
    drive(id, ur, fl, hd);
    #1;
    hz  = model_hazard(ex_m, id, ur);
    adv = !hd && (fl || !hz);
    chk("load_use_stall", {31'd0, LoadUseStall}, {31'd0, hz});
    chk("pc_write", {31'd0, PCWrite}, {31'd0, adv});
    chk("ifid_write", {31'd0, IFID_Write}, {31'd0, adv});
    if (hd)            nxt = ex_m;
    else if (fl || hz) nxt = '0;
    else               nxt = id;
    if (!hd && !fl && hz) stall_m = stall_m + 1;
    ex_m  = nxt;
    e.f   = nxt;
    e.cnt = stall_m;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: after every rising edge with a pending prediction, compare the register contents.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        #1;
        e = sb.pop_front();
        checks++;
        if (dut_ex() !== e.f) begin
          errors++;
          $display("FAIL idex_regs: actual=%h expected=%h", dut_ex(), e.f);
        end
`ifdef IDEX_STATS_EN
        checks++;
        if (StallCount !== e.cnt) begin
          errors++;
          $display("FAIL stall_count: actual=%0d expected=%0d", StallCount, e.cnt);
        end
`endif
      end
    end
  end

  initial begin
    ex_t add_i, lw5, add_dep, sw_i, addi_i, lw0, add0, rnd;
    add_i   = mk(1, 2, 3, 32'h11, 32'h22, 32'h0, 1, 0, 0, 0, 1, 0, 3'd2);
    lw5     = mk(1, 5, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0, 1, 0, 1, 3'd0);
    add_dep = mk(5, 2, 6, 32'h55, 32'h22, 32'h0, 1, 0, 0, 0, 1, 0, 3'd2);
    sw_i    = mk(5, 7, 0, 32'h55, 32'h77, 32'h0, 0, 0, 1, 0, 0, 1, 3'd0);
    addi_i  = mk(9, 5, 8, 32'h99, 32'h55, 32'h4, 1, 0, 0, 0, 0, 1, 3'd0);
    lw0     = mk(1, 0, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0, 1, 0, 1, 3'd0);
    add0    = mk(0, 0, 4, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 1, 0, 3'd2);

    ex_m = '0;
    stall_m = '0;
    reset = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("reset_regs", 32'(dut_ex() != '0), 32'd0);
    chk("reset_pc_write", {31'd0, PCWrite}, 32'd1);
    chk("reset_ifid_write", {31'd0, IFID_Write}, 32'd1);
`ifdef IDEX_STATS_EN
    chk("reset_stall_count", StallCount, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Pass-through, load-use and false-stall cases.
    cycle(add_i, 1, 0, 0);
    cycle(lw5, 0, 0, 0);
    cycle(add_dep, 1, 0, 0);
    cycle(add_dep, 1, 0, 0);
    cycle(lw5, 0, 0, 0);
    cycle(sw_i, 1, 0, 0);
    cycle(sw_i, 1, 0, 0);
    cycle(lw5, 0, 0, 0);
    cycle(addi_i, 0, 0, 0);
    cycle(lw0, 0, 0, 0);
    cycle(add0, 1, 0, 0);
    // Flush wins over a simultaneous hazard.
    cycle(lw5, 0, 0, 0);
    cycle(add_dep, 1, 1, 0);
    // Hold with changing inputs and Flush asserted, then release into a pending hazard.
    cycle(lw5, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      rnd = ex_t'({$urandom, $urandom, $urandom, $urandom});
      cycle(rnd, 1, 1, 1);
    end
    cycle(add_dep, 1, 0, 0);
    cycle(add_dep, 1, 0, 0);

    // Reset in the middle of a stall cycle drops the pending stall.
    cycle(lw5, 0, 0, 0);
    drive(add_dep, 1'b1, 1'b0, 1'b0);
    #1;
    chk("pre_reset_stall", {31'd0, LoadUseStall}, {31'd0, model_hazard(ex_m, add_dep, 1'b1)});
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_regs", 32'(dut_ex() != '0), 32'd0);
    chk("midreset_stall", {31'd0, LoadUseStall}, 32'd0);
    chk("midreset_pc_write", {31'd0, PCWrite}, 32'd1);
    chk("midreset_ifid_write", {31'd0, IFID_Write}, 32'd1);
    ex_m = '0;
    stall_m = '0;
`ifdef IDEX_STATS_EN
    chk("midreset_stall_count", StallCount, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    cycle(add_dep, 1, 0, 0);

    // Randomized traffic with a small register range so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      rnd = ex_t'({$urandom, $urandom, $urandom, $urandom});
      rnd.rs = 5'($urandom_range(0, 7));
      rnd.rt = 5'($urandom_range(0, 7));
      rnd.memread = ($urandom_range(0, 2) == 0);
      cycle(rnd, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
